pixel_filter_pipe: RTL

Parametrised, pipelined per-pixel colour filter for the VGA video path; successor to the combinational grayscale/invert stage. Sits between the pixel source (frame buffer read-out) and the VGA output register. Accepts one RGB pixel per cycle over a valid/ready stream. Applies a mode latched at frame start: pass, invert, grayscale, grayscale-invert or threshold. Reports the active mode and a frame count.

---
 rtl/pixel_filter_pipe.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_filter_pipe.sv
// rtl/pixel_filter_pipe.sv - pipelined per-pixel colour filter (pass/invert/gray/gray-invert/threshold)
// Optional brightness offset stage enabled by defining PIXFILT_BRIGHT_EN.
module pixel_filter_pipe #(
    parameter int CW      = 4,
    parameter int THR_DEF = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        mode_in,
    input  logic [CW-1:0]     thr_in,
`ifdef PIXFILT_BRIGHT_EN
    input  logic signed [CW:0] bright_in,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [CW-1:0]     in_r,
    input  logic [CW-1:0]     in_g,
    input  logic [CW-1:0]     in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic [CW-1:0]     out_r,
    output logic [CW-1:0]     out_g,
    output logic [CW-1:0]     out_b,
    output logic [2:0]        active_mode,
    output logic [15:0]       frame_cnt
);

    localparam int            SW      = CW + 2;
    localparam logic [CW-1:0] MAXV    = {CW{1'b1}};
    localparam logic [CW-1:0] THR_RST = CW'(THR_DEF);

    logic          sof_acc;
    logic [2:0]    cur_mode;
    logic [CW-1:0] cur_thr;
    logic [2:0]    snap_mode;
    logic [CW-1:0] snap_thr;

    // The whole pipe advances together; a stalled output freezes every stage.
    assign in_ready  = !(out_valid && !out_ready);
    assign sof_acc   = in_valid && in_ready && in_sof;
    assign snap_mode = (in_valid && in_sof) ? mode_in : cur_mode;
    assign snap_thr  = (in_valid && in_sof) ? thr_in  : cur_thr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_mode  <= 3'd0;
            cur_thr   <= THR_RST;
            frame_cnt <= 16'd0;
        end else if (sof_acc) begin
            cur_mode  <= mode_in;
            cur_thr   <= thr_in;
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    logic          s1_valid, s1_sof;
    logic [CW-1:0] s1_r, s1_g, s1_b, s1_thr;
    logic [SW-1:0] s1_sum;
    logic [2:0]    s1_mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            s1_sum   <= '0;
            s1_mode  <= 3'd0;
            s1_thr   <= THR_RST;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            s1_sof   <= in_valid && in_sof;
            s1_r     <= in_r;
            s1_g     <= in_g;
            s1_b     <= in_b;
            s1_sum   <= SW'(in_r) + SW'(in_g) + SW'(in_b);
            s1_mode  <= snap_mode;
            s1_thr   <= snap_thr;
        end
    end

    logic [CW-1:0] gray, f_r, f_g, f_b;

    // Sum of three channels divided by 3 always fits back into CW bits.
    always_comb begin
        gray = CW'(s1_sum / SW'(3));
        f_r  = s1_r;
        f_g  = s1_g;
        f_b  = s1_b;
        case (s1_mode)
            3'd1: begin
                f_r = MAXV - s1_r;
                f_g = MAXV - s1_g;
                f_b = MAXV - s1_b;
            end
            3'd2: begin
                f_r = gray;
                f_g = gray;
                f_b = gray;
            end
            3'd3: begin
                f_r = MAXV - gray;
                f_g = MAXV - gray;
                f_b = MAXV - gray;
            end
            3'd4: begin
                f_r = (gray >= s1_thr) ? MAXV : '0;
                f_g = (gray >= s1_thr) ? MAXV : '0;
                f_b = (gray >= s1_thr) ? MAXV : '0;
            end
            default: ;
        endcase
    end

    logic          s2_valid, s2_sof;
    logic [CW-1:0] s2_r, s2_g, s2_b;
    logic [2:0]    s2_mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_r     <= '0;
            s2_g     <= '0;
            s2_b     <= '0;
            s2_mode  <= 3'd0;
        end else if (in_ready) begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_r     <= f_r;
            s2_g     <= f_g;
            s2_b     <= f_b;
            s2_mode  <= s1_mode;
        end
    end

`ifdef PIXFILT_BRIGHT_EN
    logic signed [CW:0] cur_bright, s1_bright, s2_bright;
    logic               s3_valid, s3_sof;
    logic [CW-1:0]      s3_r, s3_g, s3_b;
    logic [2:0]         s3_mode;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] c, input logic signed [CW:0] b);
        logic signed [CW+1:0] t;
        t = $signed({2'b00, c}) + $signed({b[CW], b});
        if (t < 0)
            return '0;
        else if (t > $signed({2'b00, MAXV}))
            return MAXV;
        else
            return t[CW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_bright <= '0;
            s1_bright  <= '0;
            s2_bright  <= '0;
            s3_valid   <= 1'b0;
            s3_sof     <= 1'b0;
            s3_r       <= '0;
            s3_g       <= '0;
            s3_b       <= '0;
            s3_mode    <= 3'd0;
        end else begin
            if (sof_acc)
                cur_bright <= bright_in;
            if (in_ready) begin
                s1_bright <= (in_valid && in_sof) ? bright_in : cur_bright;
                s2_bright <= s1_bright;
                s3_valid  <= s2_valid;
                s3_sof    <= s2_sof;
                s3_r      <= sat_add(s2_r, s2_bright);
                s3_g      <= sat_add(s2_g, s2_bright);
                s3_b      <= sat_add(s2_b, s2_bright);
                s3_mode   <= s2_mode;
            end
        end
    end

    assign out_valid   = s3_valid;
    assign out_sof     = s3_sof;
    assign out_r       = s3_r;
    assign out_g       = s3_g;
    assign out_b       = s3_b;
    assign active_mode = s3_mode;
`else
    assign out_valid   = s2_valid;
    assign out_sof     = s2_sof;
    assign out_r       = s2_r;
    assign out_g       = s2_g;
    assign out_b       = s2_b;
    assign active_mode = s2_mode;
`endif

endmodule
